// File: rtl/adder_arbiter_if.sv
// Requester/consumer bus for the round-robin adder arbiter: three requesters in,
// one registered sum result out.
interface adder_arbiter_if #(
    parameter int WIDTH = 32
);
    logic [2:0]         req;
    logic [3*WIDTH-1:0] in_a;
    logic [3*WIDTH-1:0] in_b;
    logic [2:0]         gnt;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_carry;
    logic               out_ovf;
    logic [1:0]         out_tag;

    modport master (
        output req, in_a, in_b, out_ready,
        input  gnt, out_valid, out_data, out_carry, out_ovf, out_tag
    );

    modport slave (
        input  req, in_a, in_b, out_ready,
        output gnt, out_valid, out_data, out_carry, out_ovf, out_tag
    );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin arbiter over three adder requesters feeding a single registered
// result stage with carry/overflow flags and a valid/ready output handshake.
module adder_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    adder_arbiter_if.slave bus
);
    localparam int NREQ = 3;

    logic [NREQ-1:0]         gnt_p0;
    logic [1:0]              sel_p0;
    logic                    free_p0;
    logic signed [WIDTH-1:0] a_p0;
    logic signed [WIDTH-1:0] b_p0;
    logic [WIDTH:0]          sum_p0;
    logic [1:0]              ptr;

    logic                    vld_p1;
    logic [WIDTH-1:0]        data_p1;
    logic                    carry_p1;
    logic                    ovf_p1;
    logic [1:0]              tag_p1;

    // First set request at or after the pointer, wrapping 2 -> 0.
    function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [1:0] p);
        logic [NREQ-1:0] g;
        g = '0;
        case (p)
            2'd1:    g = r[1] ? 3'b010 : r[2] ? 3'b100 : r[0] ? 3'b001 : 3'b000;
            2'd2:    g = r[2] ? 3'b100 : r[0] ? 3'b001 : r[1] ? 3'b010 : 3'b000;
            default: g = r[0] ? 3'b001 : r[1] ? 3'b010 : r[2] ? 3'b100 : 3'b000;
        endcase
        return g;
    endfunction

    function automatic logic signed_ovf(input logic signed [WIDTH-1:0] a,
                                        input logic signed [WIDTH-1:0] b,
                                        input logic signed [WIDTH-1:0] s);
        return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    endfunction

    // Stage p0: arbitration and operand select in the grant cycle
    assign free_p0 = !vld_p1 || bus.out_ready;

    always_comb begin
        gnt_p0 = '0;
        if (rst_n && free_p0) begin
            gnt_p0 = rr_pick(bus.req, ptr);
        end
    end

    always_comb begin
        sel_p0 = 2'd0;
        if (gnt_p0[1]) begin
            sel_p0 = 2'd1;
        end else if (gnt_p0[2]) begin
            sel_p0 = 2'd2;
        end
    end

    always_comb begin
        a_p0 = signed'(bus.in_a[0 +: WIDTH]);
        b_p0 = signed'(bus.in_b[0 +: WIDTH]);
        case (sel_p0)
            2'd1: begin
                a_p0 = signed'(bus.in_a[WIDTH +: WIDTH]);
                b_p0 = signed'(bus.in_b[WIDTH +: WIDTH]);
            end
            2'd2: begin
                a_p0 = signed'(bus.in_a[2*WIDTH +: WIDTH]);
                b_p0 = signed'(bus.in_b[2*WIDTH +: WIDTH]);
            end
            default: ;
        endcase
    end

    assign sum_p0 = {1'b0, $unsigned(a_p0)} + {1'b0, $unsigned(b_p0)};

    // Stage p1: result register; everything holds while stalled by backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            data_p1  <= '0;
            carry_p1 <= 1'b0;
            ovf_p1   <= 1'b0;
            tag_p1   <= 2'd0;
            ptr      <= 2'd0;
        end else if (|gnt_p0) begin
            vld_p1   <= 1'b1;
            data_p1  <= sum_p0[WIDTH-1:0];
            carry_p1 <= sum_p0[WIDTH];
            ovf_p1   <= signed_ovf(a_p0, b_p0, signed'(sum_p0[WIDTH-1:0]));
            tag_p1   <= sel_p0;
            ptr      <= (sel_p0 == 2'd2) ? 2'd0 : sel_p0 + 2'd1;
        end else if (vld_p1 && bus.out_ready) begin
            vld_p1   <= 1'b0;
        end
    end

    assign bus.gnt       = gnt_p0;
    assign bus.out_valid = vld_p1;
    assign bus.out_data  = data_p1;
    assign bus.out_carry = carry_p1;
    assign bus.out_ovf   = ovf_p1;
    assign bus.out_tag   = tag_p1;
endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter: a reference arbiter predicts each grant and
// queues the expected sum, which is compared when the result register updates.
module tb_adder_arbiter;
    localparam int WIDTH = 32;

    logic clk;
    logic rst_n;

    adder_arbiter_if #(.WIDTH(WIDTH)) bus ();

    adder_arbiter #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             carry;
        logic             ovf;
        logic [1:0]       tag;
    } result_t;

    result_t    exp_q[$];
    result_t    m_last;
    logic       m_valid;
    logic [1:0] m_ptr;
    logic       pending;
    logic       track;
    int         n_checks;
    int         n_errors;
    int         waits[3];
    int         grants[3];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] model_pick(input logic [2:0] r, input logic [1:0] p);
        for (int k = 0; k < 3; k++) begin
            int idx = (int'(p) + k) % 3;
            if (r[idx]) return 3'b001 << idx;
        end
        return 3'b000;
    endfunction

    function automatic logic [3*WIDTH-1:0] pack3(input logic [WIDTH-1:0] w0,
                                                 input logic [WIDTH-1:0] w1,
                                                 input logic [WIDTH-1:0] w2);
        return {w2, w1, w0};
    endfunction

    // Predict the combinational grant for the inputs now on the bus and update the model.
    task automatic eval_grant();
        logic [2:0]       eg;
        int               i;
        result_t          r;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH:0]   s;
        eg = (rst_n && (!m_valid || bus.out_ready)) ? model_pick(bus.req, m_ptr) : 3'b000;
        check_eq("gnt", 64'(bus.gnt), 64'(eg));
        pending = 1'b0;
        if (eg != 3'b000) begin
            i = eg[0] ? 0 : (eg[1] ? 1 : 2);
            a = bus.in_a[i*WIDTH +: WIDTH];
            b = bus.in_b[i*WIDTH +: WIDTH];
            s = {1'b0, a} + {1'b0, b};
            r.data  = s[WIDTH-1:0];
            r.carry = s[WIDTH];
            r.ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
            r.tag   = 2'(i);
            exp_q.push_back(r);
            pending = 1'b1;
            m_valid = 1'b1;
            m_ptr   = 2'((i + 1) % 3);
            if (track) begin
                check_eq("starve_bound", 64'(waits[i] <= 2), 64'd1);
                waits[i] = 0;
                grants[i]++;
                for (int j = 0; j < 3; j++) begin
                    if (j != i && bus.req[j]) waits[j]++;
                end
            end
        end else if (m_valid && bus.out_ready) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic check_outputs();
        check_eq("out_valid", 64'(bus.out_valid), 64'(m_valid));
        if (pending) begin
            if (exp_q.size() == 0) begin
                check_eq("queue_empty", 64'd0, 64'd1);
            end else begin
                m_last = exp_q.pop_front();
            end
            pending = 1'b0;
        end
        check_eq("out_data",  64'(bus.out_data),  64'(m_last.data));
        check_eq("out_carry", 64'(bus.out_carry), 64'(m_last.carry));
        check_eq("out_ovf",   64'(bus.out_ovf),   64'(m_last.ovf));
        check_eq("out_tag",   64'(bus.out_tag),   64'(m_last.tag));
    endtask

    task automatic step(input logic [2:0] r, input logic [3*WIDTH-1:0] a,
                        input logic [3*WIDTH-1:0] b, input logic rdy);
        @(negedge clk);
        check_outputs();
        bus.req       = r;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.out_ready = rdy;
        #1;
        eval_grant();
    endtask

    // Asynchronous reset pulse placed between clock edges, after a step.
    task automatic reset_pulse();
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rst_data",  64'(bus.out_data),  64'd0);
        check_eq("rst_gnt",   64'(bus.gnt),       64'd0);
        check_eq("rst_tag",   64'(bus.out_tag),   64'd0);
        check_eq("rst_flags", 64'({bus.out_carry, bus.out_ovf}), 64'd0);
        exp_q.delete();
        pending = 1'b0;
        m_valid = 1'b0;
        m_ptr   = 2'd0;
        m_last  = '0;
        rst_n   = 1'b1;
        #1;
        eval_grant();
    endtask

    logic [3*WIDTH-1:0] a_inc;
    logic [3*WIDTH-1:0] b_ten;
    logic [3*WIDTH-1:0] zero3;

    initial begin
        n_checks = 0;
        n_errors = 0;
        track    = 1'b0;
        pending  = 1'b0;
        m_valid  = 1'b0;
        m_ptr    = 2'd0;
        m_last   = '0;
        for (int i = 0; i < 3; i++) begin
            waits[i]  = 0;
            grants[i] = 0;
        end
        zero3 = '0;
        a_inc = pack3(32'd1, 32'd2, 32'd3);
        b_ten = pack3(32'd10, 32'd10, 32'd10);

        bus.req       = 3'b000;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check_eq("init_valid", 64'(bus.out_valid), 64'd0);
        check_eq("init_data",  64'(bus.out_data),  64'd0);
        check_eq("init_tag",   64'(bus.out_tag),   64'd0);
        bus.req       = 3'b111;
        bus.out_ready = 1'b1;
        #1;
        check_eq("gnt_in_reset", 64'(bus.gnt), 64'd0);
        @(negedge clk);
        check_eq("gnt_in_reset_clk", 64'(bus.gnt), 64'd0);
        check_eq("valid_in_reset", 64'(bus.out_valid), 64'd0);
        bus.req = 3'b000;
        rst_n   = 1'b1;

        // Basic single transaction: 2 + 20
        step(3'b001, pack3(32'd2, 32'd0, 32'd0), pack3(32'd20, 32'd0, 32'd0), 1'b1);
        check_eq("basic_gnt", 64'(bus.gnt), 64'b001);
        step(3'b000, zero3, zero3, 1'b1);
        check_eq("basic_data", 64'(bus.out_data), 64'd22);
        check_eq("basic_tag",  64'(bus.out_tag),  64'd0);
        step(3'b000, zero3, zero3, 1'b1);
        reset_pulse();

        // Round robin with all three requesting back-to-back
        step(3'b111, a_inc, b_ten, 1'b1);
        check_eq("rr_gnt0", 64'(bus.gnt), 64'b001);
        step(3'b111, a_inc, b_ten, 1'b1);
        check_eq("rr_gnt1", 64'(bus.gnt), 64'b010);
        check_eq("rr_data0", 64'(bus.out_data), 64'd11);
        step(3'b111, a_inc, b_ten, 1'b1);
        check_eq("rr_gnt2", 64'(bus.gnt), 64'b100);
        check_eq("rr_data1", 64'(bus.out_data), 64'd12);
        step(3'b111, a_inc, b_ten, 1'b1);
        check_eq("rr_gnt3", 64'(bus.gnt), 64'b001);
        check_eq("rr_data2", 64'(bus.out_data), 64'd13);
        step(3'b000, zero3, zero3, 1'b1);
        check_eq("rr_data3", 64'(bus.out_data), 64'd11);
        check_eq("rr_tag3",  64'(bus.out_tag),  64'd0);
        step(3'b000, zero3, zero3, 1'b1);
        reset_pulse();

        // Backpressure: result held three cycles while requester 1 waits
        step(3'b001, pack3(32'd5, 32'd0, 32'd0), pack3(32'd6, 32'd0, 32'd0), 1'b1);
        for (int k = 0; k < 3; k++) begin
            step(3'b010, pack3($urandom, 32'd100, $urandom), pack3($urandom, 32'd23, $urandom), 1'b0);
            check_eq("bp_gnt", 64'(bus.gnt), 64'd0);
        end
        check_eq("bp_hold_data", 64'(bus.out_data), 64'd11);
        step(3'b010, pack3($urandom, 32'd100, $urandom), pack3($urandom, 32'd23, $urandom), 1'b1);
        check_eq("bp_release_gnt", 64'(bus.gnt), 64'b010);
        step(3'b000, pack3($urandom, $urandom, $urandom), zero3, 1'b1);
        check_eq("bp_new_data", 64'(bus.out_data), 64'd123);
        check_eq("bp_new_tag",  64'(bus.out_tag),  64'd1);
        step(3'b000, zero3, zero3, 1'b0);
        step(3'b000, zero3, zero3, 1'b1);
        step(3'b000, zero3, zero3, 1'b1);
        reset_pulse();

        // Carry and signed overflow boundaries
        step(3'b011, pack3(32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000),
             pack3(32'h0000_0001, 32'h0000_0001, 32'h8000_0000), 1'b1);
        step(3'b110, pack3(32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000),
             pack3(32'h0000_0001, 32'h0000_0001, 32'h8000_0000), 1'b1);
        check_eq("bnd0_data",  64'(bus.out_data),  64'd0);
        check_eq("bnd0_flags", 64'({bus.out_carry, bus.out_ovf}), 64'b10);
        step(3'b100, pack3(32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000),
             pack3(32'h0000_0001, 32'h0000_0001, 32'h8000_0000), 1'b1);
        check_eq("bnd1_data",  64'(bus.out_data),  64'h8000_0000);
        check_eq("bnd1_flags", 64'({bus.out_carry, bus.out_ovf}), 64'b01);
        step(3'b000, zero3, zero3, 1'b1);
        check_eq("bnd2_data",  64'(bus.out_data),  64'd0);
        check_eq("bnd2_flags", 64'({bus.out_carry, bus.out_ovf}), 64'b11);
        step(3'b000, zero3, zero3, 1'b1);

        // Reset mid-stream: first grant after release is requester 0
        step(3'b111, a_inc, b_ten, 1'b1);
        step(3'b111, a_inc, b_ten, 1'b1);
        reset_pulse();
        check_eq("post_rst_gnt", 64'(bus.gnt), 64'b001);
        step(3'b000, zero3, zero3, 1'b1);
        step(3'b000, zero3, zero3, 1'b1);

        // Fairness under random backpressure
        track = 1'b1;
        for (int c = 0; c < 200; c++) begin
            step(3'b111, pack3($urandom, $urandom, $urandom), pack3($urandom, $urandom, $urandom),
                 1'($urandom_range(0, 1)));
        end
        track = 1'b0;
        step(3'b000, zero3, zero3, 1'b1);
        step(3'b000, zero3, zero3, 1'b1);
        begin
            int mx;
            int mn;
            mx = grants[0];
            mn = grants[0];
            for (int i = 1; i < 3; i++) begin
                if (grants[i] > mx) mx = grants[i];
                if (grants[i] < mn) mn = grants[i];
            end
            check_eq("fair_spread", 64'((mx - mn) <= 1), 64'd1);
            check_eq("fair_active", 64'(mx > 0), 64'd1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits.
REQ-002 Parameter: NREQ, fixed 3, number of requesters (not overridable).
REQ-003 Port: clk  input  1  system clock, all state updates on posedge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: req  input  3  per-requester request, bit i = requester i.
REQ-006 Port: in_a  input  3*WIDTH  operand A, slice i = bits [i*WIDTH +: WIDTH].
REQ-007 Port: in_b  input  3*WIDTH  operand B, same slicing.
REQ-008 Port: gnt  output  3  one-hot grant, combinational, at most one bit set.
REQ-009 Port: out_valid  output  1  result register holds an unconsumed result.
REQ-010 Port: out_ready  input  1  consumer accepts result this cycle.
REQ-011 Port: out_data  output  WIDTH  registered sum, in_a + in_b modulo 2^WIDTH.
REQ-012 Port: out_carry  output  1  registered unsigned carry-out of the sum.
REQ-013 Port: out_ovf  output  1  registered signed overflow: operand signs equal, sum sign differs.
REQ-014 Port: out_tag  output  2  registered index of the granted requester (0..2).

Function
REQ-015 Stage free = !out_valid || out_ready; combinational.
REQ-016 gnt SHALL be nonzero only when stage free, req nonzero, and rst_n high.
REQ-017 Arbitration SHALL be round-robin: search from pointer ptr (0..2) upward, wrap 2->0, grant first set req bit.
REQ-018 On posedge with gnt[i]=1: out_data/out_carry/out_ovf <= result of slice i, out_tag <= i, out_valid <= 1, ptr <= (i+1) mod 3.
REQ-019 Latency: exactly one clock from grant cycle to out_valid with that result.
REQ-020 Throughput: one grant per cycle when out_ready held high (back-to-back, no bubble).
REQ-021 On posedge with out_valid && out_ready && no grant: out_valid <= 0; out_data/flags/tag hold last values.
REQ-022 On posedge with out_valid && !out_ready: all result registers and ptr hold; gnt = 0 that cycle.
REQ-023 ptr SHALL change only on a grant; no grant -> ptr holds.
REQ-024 Requester protocol: requester holds req and operands stable until it sees its gnt bit high in a cycle; req deassertion before grant is legal and drops the request without side effect.
REQ-025 Operands SHALL be sampled only in the grant cycle; changes in other cycles have no effect.
REQ-026 Single requester continuously asserting with out_ready high SHALL be granted every cycle.
REQ-027 Starvation bound: an asserted request SHALL be granted within 3 grant events.
REQ-028 Carry/overflow computed on full WIDTH; e.g. 0xFFFFFFFF+1 -> data 0, carry 1, ovf 0; 0x7FFFFFFF+1 -> data 0x80000000, carry 0, ovf 1.

Reset
REQ-029 rst_n low SHALL immediately (asynchronously) force out_valid=0, out_data=0, out_carry=0, out_ovf=0, out_tag=0, ptr=0, gnt=0.
REQ-030 Reset asserted mid-operation discards any pending result; no grant is issued while rst_n is low.
REQ-031 First posedge after rst_n rises SHALL arbitrate normally with ptr=0.

Verification
REQ-032 Reset, then req=001, a0=2, b0=20, out_ready=1 -> gnt=001 same cycle; next cycle out_valid=1, out_data=22, out_tag=0, carry=0, ovf=0.
REQ-033 req=111 held, all three slices a=i+1,b=10, out_ready=1 -> grants 001,010,100,001 on consecutive cycles; out_data 11,12,13,11 with tags 0,1,2,0.
REQ-034 Backpressure: result valid with out_ready=0 for 3 cycles, req=010 -> gnt=0, out_data/tag stable 3 cycles; out_ready=1 -> gnt=010 same cycle, new result next cycle.
REQ-035 Boundaries: slice 0 = 0xFFFFFFFF+0x00000001 -> data 0, carry 1, ovf 0; slice 1 = 0x7FFFFFFF+0x00000001 -> data 0x80000000, carry 0, ovf 1.
REQ-036 Reset mid-stream: req=111 running, rst_n pulsed low between clock edges -> out_valid, out_data, gnt drop to 0 immediately; after release first grant is requester 0.
REQ-037 Fairness: req=111 with out_ready toggling randomly for 200 cycles -> no requester waits more than 3 grants; grant count per requester differs by at most 1.
